spi_reg_write_rx: RTL and testbench

- SPI-mode-0 write-only slave front end inside tt_um_camdenmil_sky25b. Directly consumes the uio_in SPI pins driven by the board and the test bench: cs on uio_in[0], mosi on uio_in[2], sck on uio_in[3].
- Oversamples the SPI pins in the clk domain and assembles MSB-first bytes.
- Decodes a command byte followed by data bytes, and issues single-cycle register-write strobes to the downstream register file.
- MISO is not driven; the bus is write-only.

---
 rtl/spi_rx_pkg.sv | 15 +
 rtl/spi_sync.sv | 42 ++++
 rtl/spi_reg_write_rx.sv | 167 ++++++++++++++++
 tb/tb_spi_reg_write_rx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the SPI register-write receiver.
// FSM state encoding plus byte/command field positions.
package spi_rx_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned CMD_WR_BIT = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        DATA    = 2'd2,
        DISCARD = 2'd3
    } state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchronizer for one SPI pin with registered edge detection.
// level, rise and fall are all registered so they stay mutually aligned.
module spi_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_out;
            rise_q <= sync_out & ~prev_q;
            fall_q <= ~sync_out & prev_q;
        end
    end

    // prev_q carries the same delay as the edge flags, so callers see them in step
    assign level = prev_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/spi_reg_write_rx.sv
// SPI mode-0 write-only slave: oversamples cs_n/sck/mosi, assembles MSB-first
// bytes and turns a write command plus data bytes into register-write strobes.
module spi_reg_write_rx
    import spi_rx_pkg::*;
#(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    input  logic              spi_sck,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [BYTE_W-1:0] wr_data,
    output logic              frame_active,
    output logic              frame_err
);

    logic cs_level;
    logic cs_rise;
    logic cs_fall;
    logic sck_rise;
    logic mosi_level;
    logic unused_sck_level;
    logic unused_sck_fall;
    logic unused_mosi_rise;
    logic unused_mosi_fall;

    spi_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_cs_n),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_sck (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_sck),
        .level (unused_sck_level),
        .rise  (sck_rise),
        .fall  (unused_sck_fall)
    );

    spi_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_mosi (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_mosi),
        .level (mosi_level),
        .rise  (unused_mosi_rise),
        .fall  (unused_mosi_fall)
    );

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [BYTE_W-1:0] wr_data_q, wr_data_d;
    logic              frame_active_q, frame_active_d;
    logic              frame_err_q, frame_err_d;
    logic [SYNC_STAGES:0] warm_q;
    logic              armed_q, armed_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        shreg_d        = shreg_q;
        done_d         = 1'b0;
        addr_d         = addr_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        frame_active_d = ~cs_level;
        frame_err_d    = cs_rise && (cnt_q != 3'd0);
        // Only accept frames once cs_n has been seen high with a flushed synchronizer
        armed_d        = armed_q | (warm_q[SYNC_STAGES] & cs_level);

        // A byte completed on the previous cycle; shreg_q now holds it whole
        if (done_q) begin
            unique case (state_q)
                CMD: begin
                    if (shreg_q[CMD_WR_BIT]) begin
                        addr_d  = shreg_q[ADDR_W-1:0];
                        state_d = DATA;
                    end else begin
                        state_d = DISCARD;
                    end
                end
                DATA: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = shreg_q;
                    addr_d    = addr_q + ADDR_W'(1);
                end
                default: ;
            endcase
        end

        // cs_n high outranks any sck edge seen in the same cycle
        if (cs_level) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            shreg_d = '0;
        end else if (state_q == IDLE) begin
            if (cs_fall && armed_q) begin
                state_d = CMD;
            end
        end else if (sck_rise) begin
            shreg_d = {shreg_q[BYTE_W-2:0], mosi_level};
            cnt_d   = cnt_q + 3'd1;
            done_d  = (cnt_q == 3'(BYTE_W - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= 3'd0;
            shreg_q        <= '0;
            done_q         <= 1'b0;
            addr_q         <= '0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            frame_active_q <= 1'b0;
            frame_err_q    <= 1'b0;
            warm_q         <= '0;
            armed_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shreg_q        <= shreg_d;
            done_q         <= done_d;
            addr_q         <= addr_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            frame_active_q <= frame_active_d;
            frame_err_q    <= frame_err_d;
            warm_q         <= {warm_q[SYNC_STAGES-1:0], 1'b1};
            armed_q        <= armed_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign frame_active = frame_active_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_spi_reg_write_rx.sv
// Scoreboard bench for spi_reg_write_rx: directed and random SPI frames are
// modelled at transaction level; a monitor checks every strobe as it appears.
module tb_spi_reg_write_rx;

    localparam int unsigned ADDR_W      = 7;
    localparam int unsigned SYNC_STAGES = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              spi_cs_n;
    logic              spi_mosi;
    logic              spi_sck;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              frame_active;
    logic              frame_err;

    always #5 clk = ~clk;

    spi_reg_write_rx #(
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_cs_n     (spi_cs_n),
        .spi_mosi     (spi_mosi),
        .spi_sck      (spi_sck),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_active (frame_active),
        .frame_err    (frame_err)
    );

    int total     = 0;
    int bad       = 0;
    int cyc       = 0;
    int lat_start = 0;
    int err_seen  = 0;
    int err_exp   = 0;

    logic [ADDR_W+7:0] exp_q[$];
    logic [ADDR_W+7:0] mon_e;
    logic [7:0]        frame_bytes[$];

    function automatic void chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, want, $time);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: counts error pulses and checks each strobe against the scoreboard
    always @(negedge clk) begin
        if (frame_err) err_seen <= err_seen + 1;
        if (wr_en) begin
            chk("pending_at_strobe", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", int'(wr_addr), int'(mon_e[ADDR_W+7:8]));
                chk("wr_data", int'(wr_data), int'(mon_e[7:0]));
                chk("latency", cyc - lat_start, int'(SYNC_STAGES) + 2);
            end
        end
    end

    task automatic send_bit(input logic b, input bit last);
        spi_mosi = b;
        repeat (4) @(negedge clk);
        spi_sck = 1'b1;
        // the next posedge is the first to sample this raw sck high
        if (last) lat_start = cyc + 1;
        repeat (4) @(negedge clk);
        spi_sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i], i == 0);
    endtask

    // Reference model: a write command addresses the following data bytes,
    // incrementing modulo 2^ADDR_W; a partial trailing byte is a framing error.
    task automatic model_frame(input int tail);
        int a;
        if (frame_bytes.size() > 0 && frame_bytes[0][7]) begin
            a = int'(frame_bytes[0]) % (1 << ADDR_W);
            for (int i = 1; i < frame_bytes.size(); i++) begin
                exp_q.push_back({a[ADDR_W-1:0], frame_bytes[i]});
                a = (a + 1) % (1 << ADDR_W);
            end
        end
        if (tail > 0) err_exp++;
    endtask

    task automatic end_frame();
        repeat (8) @(negedge clk);
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
        chk("drained", exp_q.size(), 0);
        chk("frame_err_count", err_seen, err_exp);
        chk("frame_active_out", int'(frame_active), 0);
    endtask

    task automatic send_frame(input int tail, input logic [7:0] tail_val);
        model_frame(tail);
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("frame_active_in", int'(frame_active), 1);
        foreach (frame_bytes[i]) send_byte(frame_bytes[i]);
        for (int i = 0; i < tail; i++) send_bit(tail_val[7-i], 1'b0);
        repeat (2) @(negedge clk);
        spi_cs_n = 1'b1;
        end_frame();
    endtask

    initial begin
        logic [7:0] v;
        int         n;
        int         tail;

        rst_n    = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        spi_sck  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({wr_en, wr_addr, wr_data, frame_active, frame_err}), 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        frame_bytes = '{8'h85, 8'h3C};
        send_frame(0, 8'h00);
        frame_bytes = '{8'hFE, 8'h11, 8'h22, 8'h33};
        send_frame(0, 8'h00);
        frame_bytes = '{8'h05, 8'hAA, 8'h55};
        send_frame(0, 8'h00);
        frame_bytes = '{8'h81, 8'hF0};
        send_frame(4, 8'hA0);
        frame_bytes = '{8'h82, 8'h99};
        send_frame(0, 8'h00);

        // Reset after 12 bits; the frame still open at release must be ignored
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'h83);
        v = 8'h44;
        for (int i = 0; i < 4; i++) send_bit(v[7-i], 1'b0);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_frame", int'({wr_en, wr_addr, wr_data, frame_active, frame_err}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        send_byte(8'h85);
        send_byte(8'h66);
        repeat (2) @(negedge clk);
        spi_cs_n = 1'b1;
        end_frame();

        frame_bytes = '{8'h83, 8'h44};
        send_frame(0, 8'h00);

        for (int f = 0; f < 12; f++) begin
            frame_bytes.delete();
            n = int'($urandom_range(1, 5));
            for (int i = 0; i < n; i++) frame_bytes.push_back(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) != 0) frame_bytes[0][7] = 1'b1;
            tail = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            send_frame(tail, 8'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
